// File: rtl/mdu_unit_if.sv
// ============================================================================
// mdu_unit_if : operand/command/result bundle between EX and the MD unit
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mdu_unit_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, rs_data, rt_data,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdop, rs_data, rt_data,
        output busy, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// mdu_unit : fixed-latency mult/multu/div/divu unit holding architectural HI/LO
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mdu_unit_if.slave  bus
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [63:0]        pend_q,  pend_d;
    logic [31:0]        hi_q,    hi_d;
    logic [31:0]        lo_q,    lo_d;

    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] sden;
    logic [31:0] uden;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;
    logic        rt_zero;

    assign rs = bus.rs_data;
    assign rt = bus.rt_data;

    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign smul = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign umul = {32'd0, rs} * {32'd0, rt};

    // Signed divide on magnitudes avoids the 0x80000000 / -1 overflow corner
    assign rs_mag  = rs[31] ? (~rs + 32'd1) : rs;
    assign rt_mag  = rt[31] ? (~rt + 32'd1) : rt;
    assign rt_zero = (rt == 32'd0);
    assign sden    = rt_zero ? 32'd1 : rt_mag;
    assign uden    = rt_zero ? 32'd1 : rt;
    assign sq_mag  = rs_mag / sden;
    assign sr_mag  = rs_mag % sden;
    assign sq      = (rs[31] ^ rt[31]) ? (~sq_mag + 32'd1) : sq_mag;
    assign sr      = rs[31] ? (~sr_mag + 32'd1) : sr_mag;
    assign uq      = rs / uden;
    assign ur      = rs % uden;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Result is captured at the start edge, so operands need not be held
                    case (bus.mdop)
                        OP_MULT: begin
                            pend_d  = smul;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MULTU: begin
                            pend_d  = umul;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIV: begin
                            pend_d  = rt_zero ? {hi_q, lo_q} : {sr, sq};
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_DIVU: begin
                            pend_d  = rt_zero ? {hi_q, lo_q} : {ur, uq};
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// tb_mdu_unit : directed scoreboard bench for mdu_unit
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_unit;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit_if bus_if();

    mdu_unit #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Issue one mult/div op, count busy cycles, then pop and compare HI/LO
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int cyc, input logic [63:0] exp);
        logic [63:0] e;
        logic [63:0] prev;
        int n;
        exp_q.push_back(exp);
        prev = {m_hi, m_lo};
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.mdop    = op;
        bus_if.rs_data = a;
        bus_if.rt_data = b;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.mdop  = 3'd0;
        n = 0;
        while (bus_if.busy === 1'b1 && n < 60) begin
            if (n == 1) check({tag, "_hold"}, {bus_if.hi, bus_if.lo}, prev);
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(cyc));
        e = exp_q.pop_front();
        check({tag, "_hilo"}, {bus_if.hi, bus_if.lo}, e);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
    endtask

    // Single-cycle command (mthi/mtlo/none/reserved): no busy, one-edge latency
    task automatic one_cycle_op(input string tag, input logic [2:0] op, input logic [31:0] a);
        logic [63:0] e;
        if (op == 3'd5)      m_hi = a;
        else if (op == 3'd6) m_lo = a;
        exp_q.push_back({m_hi, m_lo});
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.mdop    = op;
        bus_if.rs_data = a;
        bus_if.rt_data = 32'h0;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.mdop  = 3'd0;
        check({tag, "_busy"}, 64'(bus_if.busy), 64'd0);
        e = exp_q.pop_front();
        check({tag, "_hilo"}, {bus_if.hi, bus_if.lo}, e);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            assert (!(bus_if.busy && bus_if.start))
            else begin
                failures++;
                $error("FAIL stall_contract observed=start_while_busy expected=no_start");
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        m_hi           = 32'h0;
        m_lo           = 32'h0;
        reset          = 1'b0;
        bus_if.start   = 1'b0;
        bus_if.mdop    = 3'd0;
        bus_if.rs_data = 32'h0;
        bus_if.rt_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("reset_idle_busy", 64'(bus_if.busy), 64'd0);
            check("reset_idle_hilo", {bus_if.hi, bus_if.lo}, 64'd0);
        end

        run_op("mult_neg",  3'd1, 32'hFFFFFFFE, 32'd3, 5, {32'hFFFFFFFF, 32'hFFFFFFFA});
        run_op("multu",     3'd2, 32'hFFFFFFFE, 32'd3, 5, {32'h00000002, 32'hFFFFFFFA});
        run_op("div_neg",   3'd3, 32'hFFFFFFF9, 32'd2, 10, {32'hFFFFFFFF, 32'hFFFFFFFD});
        run_op("div_negdv", 3'd3, 32'd7, 32'hFFFFFFFE, 10, {32'h00000001, 32'hFFFFFFFD});
        run_op("div_ovf",   3'd3, 32'h80000000, 32'hFFFFFFFF, 10, {32'h00000000, 32'h80000000});
        run_op("divu",      3'd4, 32'd100, 32'd7, 10, {32'd2, 32'd14});
        run_op("mult_min",  3'd1, 32'h80000000, 32'h80000000, 5, {32'h40000000, 32'h00000000});
        run_op("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, {32'hFFFFFFFE, 32'h00000001});

        one_cycle_op("mthi_11", 3'd5, 32'h11);
        one_cycle_op("mtlo_22", 3'd6, 32'h22);
        run_op("divu_zero", 3'd4, 32'd5, 32'd0, 10, {32'h11, 32'h22});
        run_op("div_zero",  3'd3, 32'hFFFFFFF0, 32'd0, 10, {32'h11, 32'h22});

        one_cycle_op("nop_op0",  3'd0, 32'hDEAD0000);
        one_cycle_op("nop_op7",  3'd7, 32'hDEAD0007);

        one_cycle_op("mthi_abcd", 3'd5, 32'h0000ABCD);
        run_op("mult_2x3", 3'd1, 32'd2, 32'd3, 5, {32'h0, 32'd6});

        // Back-to-back: new op issued in the cycle after busy falls
        run_op("b2b_a", 3'd2, 32'd10, 32'd10, 5, {32'h0, 32'd100});
        run_op("b2b_b", 3'd4, 32'd100, 32'd9, 10, {32'd1, 32'd11});

        one_cycle_op("mthi_55", 3'd5, 32'h55);
        one_cycle_op("mtlo_66", 3'd6, 32'h66);
        @(negedge clk);
        bus_if.start   = 1'b1;
        bus_if.mdop    = 3'd3;
        bus_if.rs_data = 32'd1000;
        bus_if.rt_data = 32'd3;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        bus_if.mdop  = 3'd0;
        check("abort_busy_before", 64'(bus_if.busy), 64'd1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_busy_async", 64'(bus_if.busy), 64'd0);
        check("abort_hilo_async", {bus_if.hi, bus_if.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'h0;
        m_lo = 32'h0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_busy_after", 64'(bus_if.busy), 64'd0);
        check("abort_hilo_after", {bus_if.hi, bus_if.lo}, 64'd0);

        run_op("post_reset", 3'd1, 32'd7, 32'hFFFFFFFF, 5, {32'hFFFFFFFF, 32'hFFFFFFF9});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
